lsu: RTL

Load/store unit sitting directly downstream of the integer ALU in the execute stage: takes the ALU sum (rs1 + imm) as effective address, rs2 as store data, and funct3 as access size/sign. Runs one memory transaction at a time over a request/grant/response bus, formats store byte lanes and extracts/extends load data. Returns one result, with error cause, to writeback.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking them.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3Lb  = 3'b000,
    F3Lh  = 3'b001,
    F3Lw  = 3'b010,
    F3Lbu = 3'b100,
    F3Lhu = 3'b101
  } f3_load_e;

  typedef enum logic [2:0] {
    F3Sb = 3'b000,
    F3Sh = 3'b001,
    F3Sw = 3'b010
  } f3_store_e;

  typedef enum logic [1:0] {
    CauseNone     = 2'd0,
    CauseMisalign = 2'd1,
    CauseTimeout  = 2'd2,
    CauseIllegal  = 2'd3
  } lsu_cause_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MisalignTrapEn = 1'b1;
`else
  localparam bit MisalignTrapEn = 1'b0;
`endif

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: request checks on the incoming request, store lane/strobe
// formatting and load extraction on the latched request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        chk_we_i,
  input  logic [2:0]  chk_funct3_i,
  input  logic [1:0]  chk_addr_i,
  output logic        illegal_o,
  output logic        misalign_o,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  shamt;
  logic [31:0] lane;

  always_comb begin
    if (chk_we_i) begin
      illegal_o = chk_funct3_i > 3'd2;
    end else begin
      case (chk_funct3_i)
        F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu: illegal_o = 1'b0;
        default:                        illegal_o = 1'b1;
      endcase
    end
    misalign_o = MisalignTrapEn &&
                 ((chk_funct3_i[1:0] == 2'b01 && chk_addr_i[0]) ||
                  (chk_funct3_i[1:0] == 2'b10 && chk_addr_i != 2'b00));
  end

  always_comb begin
    case (funct3_i)
      F3Sb: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << addr_i;
      end
      F3Sh: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = 4'b0011 << {addr_i[1], 1'b0};
      end
      default: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
      end
    endcase
  end

  // Offset masked to natural alignment, so misaligned accesses read the aligned container.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   shamt = addr_i;
      2'b01:   shamt = {addr_i[1], 1'b0};
      default: shamt = 2'b00;
    endcase
    lane = rdata_i >> {shamt, 3'b000};
    case (funct3_i)
      F3Lb:    rdata_o = {{24{lane[7]}}, lane[7:0]};
      F3Lh:    rdata_o = {{16{lane[15]}}, lane[15:0]};
      F3Lbu:   rdata_o = {24'b0, lane[7:0]};
      F3Lhu:   rdata_o = {16'b0, lane[15:0]};
      default: rdata_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction at a time, request/grant/response bus, single-cycle
// result pulse to writeback. Misalignment trapping is enabled by LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [1:0]  rsp_cause_o
);

  // One extra count of headroom: a grant on the last allowed cycle enters WAIT already expired.
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  lsu_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic           expired;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [31:0]    addr_q, wdata_q;
  logic [4:0]     rd_q;
  logic [31:0]    data_q, data_d;
  logic           err_q, err_d;
  lsu_cause_e     cause_q, cause_d;

  logic           accept, illegal, misalign;
  logic [3:0]     fmt_wstrb;
  logic [31:0]    fmt_wdata, load_data;
  logic           in_req, in_resp;

  assign accept = (state_q == StIdle) && req_valid_i;

  lsu_align u_align (
    .chk_we_i    (req_we_i),
    .chk_funct3_i(req_funct3_i),
    .chk_addr_i  (req_addr_i[1:0]),
    .illegal_o   (illegal),
    .misalign_o  (misalign),
    .funct3_i    (f3_q),
    .addr_i      (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata_i),
    .wstrb_o     (fmt_wstrb),
    .wdata_o     (fmt_wdata),
    .rdata_o     (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    cause_d = cause_q;
    cnt_inc = cnt_q + CntW'(1);
    expired = cnt_inc >= CntMax;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          data_d  = '0;
          err_d   = 1'b0;
          cause_d = CauseNone;
          cnt_d   = '0;
          if (illegal) begin
            state_d = StResp;
            err_d   = 1'b1;
            cause_d = CauseIllegal;
          end else if (misalign) begin
            state_d = StResp;
            err_d   = 1'b1;
            cause_d = CauseMisalign;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        if (mem_gnt_i) begin
          state_d = StWait;
        end else if (expired) begin
          state_d = StResp;
          err_d   = 1'b1;
          cause_d = CauseTimeout;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (mem_rvalid_i) begin
          state_d = StResp;
          data_d  = we_q ? '0 : load_data;
        end else if (expired) begin
          state_d = StResp;
          err_d   = 1'b1;
          cause_d = CauseTimeout;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      rd_q    <= req_rd_i;
    end
  end

  assign in_req  = (state_q == StReq);
  assign in_resp = (state_q == StResp);

  assign req_ready_o = (state_q == StIdle);
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && we_q;
  assign mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wstrb_o = (in_req && we_q) ? fmt_wstrb : '0;
  assign mem_wdata_o = (in_req && we_q) ? fmt_wdata : '0;

  assign rsp_valid_o = in_resp;
  assign rsp_rd_o    = in_resp ? rd_q : '0;
  assign rsp_data_o  = in_resp ? data_q : '0;
  assign rsp_err_o   = in_resp && err_q;
  assign rsp_cause_o = in_resp ? cause_q : CauseNone;

endmodule
